// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared SM83 ALU types, op codes and flag bit positions
package sm83_pkg;

  typedef enum logic [2:0] {
    ALU_COPY_A   = 3'd0,
    ALU_COPY_B   = 3'd1,
    ALU_INC_B    = 3'd2,
    ALU_DEC_B    = 3'd3,
    ALU_ADD_LO   = 3'd4,
    ALU_ADD_HI   = 3'd5,
    ALU_INST_ALU = 3'd6,
    ALU_INST_ACC = 3'd7
  } alu_op_e;

  typedef enum logic [0:0] {
    SEL_A_ACC  = 1'b0,
    SEL_A_REG1 = 1'b1
  } alu_sel_a_e;

  typedef enum logic [0:0] {
    SEL_B_REG2 = 1'b0,
    SEL_B_SIGN = 1'b1
  } alu_sel_b_e;

  typedef enum logic [1:0] {
    FLAG_SET_NONE    = 2'd0,
    FLAG_SET_ALL     = 2'd1,
    FLAG_SET_KEEP_Z  = 2'd2,
    FLAG_SET_CLEAR_Z = 2'd3
  } alu_flag_set_e;

  // Bit positions inside the 4-bit {Z,N,H,C} flag vector
  localparam int FLAG_C = 0;
  localparam int FLAG_H = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;

  // Core op codes not derived directly from instruction bits
  localparam logic [4:0] CORE_ADD_LO = 5'b00000;
  localparam logic [4:0] CORE_ADD_HI = 5'b00001;
  localparam logic [4:0] CORE_COPY_A = 5'b11000;
  localparam logic [4:0] CORE_COPY_B = 5'b11001;
  localparam logic [4:0] CORE_INC_B  = 5'b11010;
  localparam logic [4:0] CORE_DEC_B  = 5'b11011;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  localparam logic [2:0] ACC_RLCA = 3'd0;
  localparam logic [2:0] ACC_RRCA = 3'd1;
  localparam logic [2:0] ACC_RLA  = 3'd2;
  localparam logic [2:0] ACC_RRA  = 3'd3;
  localparam logic [2:0] ACC_DAA  = 3'd4;
  localparam logic [2:0] ACC_CPL  = 3'd5;
  localparam logic [2:0] ACC_SCF  = 3'd6;
  localparam logic [2:0] ACC_CCF  = 3'd7;

  function automatic logic [3:0] pack_flags(input logic z, input logic n, input logic h,
                                            input logic c);
    return {z, n, h, c};
  endfunction

endpackage

// File: rtl/sm83_alu_core.sv
// rtl/sm83_alu_core.sv - combinational SM83 ALU core: 5-bit op, operands and flags in, result and flags out
module sm83_alu_core
  import sm83_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [4:0] op,
  input  logic [3:0] flag_in,
  output logic [7:0] out,
  output logic [3:0] flag_out
);

  logic       z_in, n_in, h_in, c_in, use_c;
  logic [8:0] add_res, sub_res;
  logic       add_h, sub_h;
  logic       daa_hi, daa_lo;
  logic [7:0] daa_adj, daa_res, inc_res, dec_res;

  assign z_in = flag_in[FLAG_Z];
  assign n_in = flag_in[FLAG_N];
  assign h_in = flag_in[FLAG_H];
  assign c_in = flag_in[FLAG_C];

  // Carry-in only for ADC/SBC; CP shares op[0]=1 but must ignore it
  assign use_c = c_in & op[0] & ~op[2];

  assign add_res = {1'b0, a} + {1'b0, b} + {8'd0, use_c};
  assign sub_res = {1'b0, a} - {1'b0, b} - {8'd0, use_c};

  // Carry/borrow into bit 4 recovered from the bit-4 sum: a4 ^ b4 ^ r4
  assign add_h = a[4] ^ b[4] ^ add_res[4];
  assign sub_h = a[4] ^ b[4] ^ sub_res[4];

  assign daa_hi  = n_in ? c_in : (c_in | (a > 8'h99));
  assign daa_lo  = n_in ? h_in : (h_in | (a[3:0] > 4'd9));
  assign daa_adj = {1'b0, daa_hi, daa_hi, 2'b00, daa_lo, daa_lo, 1'b0};
  assign daa_res = n_in ? (a - daa_adj) : (a + daa_adj);

  assign inc_res = b + 8'd1;
  assign dec_res = b - 8'd1;

  always_comb begin
    out      = a;
    flag_out = flag_in;
    case (op[4:3])
      2'b00: begin
        case (op[2:0])
          OP_ADD, OP_ADC: begin
            out      = add_res[7:0];
            flag_out = pack_flags(add_res[7:0] == 8'd0, 1'b0, add_h, add_res[8]);
          end
          OP_SUB, OP_SBC: begin
            out      = sub_res[7:0];
            flag_out = pack_flags(sub_res[7:0] == 8'd0, 1'b1, sub_h, sub_res[8]);
          end
          OP_AND: begin
            out      = a & b;
            flag_out = pack_flags((a & b) == 8'd0, 1'b0, 1'b1, 1'b0);
          end
          OP_XOR: begin
            out      = a ^ b;
            flag_out = pack_flags((a ^ b) == 8'd0, 1'b0, 1'b0, 1'b0);
          end
          OP_OR: begin
            out      = a | b;
            flag_out = pack_flags((a | b) == 8'd0, 1'b0, 1'b0, 1'b0);
          end
          default: begin
            out      = a;
            flag_out = pack_flags(sub_res[7:0] == 8'd0, 1'b1, sub_h, sub_res[8]);
          end
        endcase
      end
      2'b01: begin
        case (op[2:0])
          ACC_RLCA: begin
            out      = {a[6:0], a[7]};
            flag_out = pack_flags(1'b0, 1'b0, 1'b0, a[7]);
          end
          ACC_RRCA: begin
            out      = {a[0], a[7:1]};
            flag_out = pack_flags(1'b0, 1'b0, 1'b0, a[0]);
          end
          ACC_RLA: begin
            out      = {a[6:0], c_in};
            flag_out = pack_flags(1'b0, 1'b0, 1'b0, a[7]);
          end
          ACC_RRA: begin
            out      = {c_in, a[7:1]};
            flag_out = pack_flags(1'b0, 1'b0, 1'b0, a[0]);
          end
          ACC_DAA: begin
            out      = daa_res;
            flag_out = pack_flags(daa_res == 8'd0, n_in, 1'b0, daa_hi);
          end
          ACC_CPL: begin
            out      = ~a;
            flag_out = pack_flags(z_in, 1'b1, 1'b1, c_in);
          end
          ACC_SCF: begin
            out      = a;
            flag_out = pack_flags(z_in, 1'b0, 1'b0, 1'b1);
          end
          default: begin
            out      = a;
            flag_out = pack_flags(z_in, 1'b0, 1'b0, ~c_in);
          end
        endcase
      end
      2'b11: begin
        case (op)
          CORE_COPY_B: out = b;
          CORE_INC_B: begin
            out      = inc_res;
            flag_out = pack_flags(inc_res == 8'd0, 1'b0, b[3:0] == 4'hF, c_in);
          end
          CORE_DEC_B: begin
            out      = dec_res;
            flag_out = pack_flags(dec_res == 8'd0, 1'b1, b[3:0] == 4'h0, c_in);
          end
          default: out = a;
        endcase
      end
      default: out = a;
    endcase
  end

endmodule

// File: rtl/sm83_alu_unit.sv
// rtl/sm83_alu_unit.sv - SM83 ALU slice: operand select, op encode, flag-set mask and internal carry
module sm83_alu_unit
  import sm83_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] t_cycle,
  input  logic [2:0] alu_op,
  input  logic       alu_sel_a,
  input  logic       alu_sel_b,
  input  logic [1:0] alu_flag_set,
  input  logic [2:0] inst_op,
  input  logic [7:0] reg_a,
  input  logic [7:0] reg1,
  input  logic [7:0] reg2,
  input  logic [3:0] flag_read,
  output logic [7:0] alu_out,
  output logic [3:0] flag_next,
  output logic       flag_write
);

  alu_op_e       op;
  alu_flag_set_e flag_set;
  logic [7:0]    a, b;
  logic [4:0]    core_op;
  logic [3:0]    core_flag_in, core_flag_out;
  logic          icarry;

  assign op       = alu_op_e'(alu_op);
  assign flag_set = alu_flag_set_e'(alu_flag_set);

  assign a = (alu_sel_a_e'(alu_sel_a) == SEL_A_REG1) ? reg1 : reg_a;
  assign b = (alu_sel_b_e'(alu_sel_b) == SEL_B_SIGN) ? {8{reg2[7]}} : reg2;

  always_comb begin
    core_op = CORE_COPY_A;
    case (op)
      ALU_COPY_A:   core_op = CORE_COPY_A;
      ALU_COPY_B:   core_op = CORE_COPY_B;
      ALU_INC_B:    core_op = CORE_INC_B;
      ALU_DEC_B:    core_op = CORE_DEC_B;
      ALU_ADD_LO:   core_op = CORE_ADD_LO;
      ALU_ADD_HI:   core_op = CORE_ADD_HI;
      ALU_INST_ALU: core_op = {2'b00, inst_op};
      ALU_INST_ACC: core_op = {2'b01, inst_op};
      default:      core_op = CORE_COPY_A;
    endcase
  end

  // High byte of a 16-bit add sees only the carry saved from the low byte
  assign core_flag_in = (op == ALU_ADD_HI) ? {3'b000, icarry} : flag_read;

  sm83_alu_core u_core (
    .a        (a),
    .b        (b),
    .op       (core_op),
    .flag_in  (core_flag_in),
    .out      (alu_out),
    .flag_out (core_flag_out)
  );

  always_comb begin
    flag_next = core_flag_in;
    case (flag_set)
      FLAG_SET_NONE:    flag_next = core_flag_in;
      FLAG_SET_ALL:     flag_next = core_flag_out;
      FLAG_SET_KEEP_Z:  flag_next = {flag_read[FLAG_Z], core_flag_out[FLAG_N:FLAG_C]};
      FLAG_SET_CLEAR_Z: flag_next = {1'b0, core_flag_out[FLAG_N:FLAG_C]};
      default:          flag_next = core_flag_in;
    endcase
  end

  assign flag_write = (flag_set != FLAG_SET_NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      icarry <= 1'b0;
    end else if (t_cycle == 2'd3 && op == ALU_ADD_LO) begin
      icarry <= core_flag_out[FLAG_C];
    end
  end

endmodule

// File: tb/tb_sm83_alu_unit.sv
// tb/tb_sm83_alu_unit.sv - randomized and directed self-checking bench for sm83_alu_unit
module tb_sm83_alu_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] t_cycle;
  logic [2:0] alu_op;
  logic       alu_sel_a, alu_sel_b;
  logic [1:0] alu_flag_set;
  logic [2:0] inst_op;
  logic [7:0] reg_a, reg1, reg2;
  logic [3:0] flag_read;
  logic [7:0] alu_out;
  logic [3:0] flag_next;
  logic       flag_write;

  int   total = 0;
  int   bad = 0;
  logic m_icarry = 1'b0;

  always #5 clk = ~clk;

  sm83_alu_unit dut (
    .clk          (clk),
    .reset        (reset),
    .t_cycle      (t_cycle),
    .alu_op       (alu_op),
    .alu_sel_a    (alu_sel_a),
    .alu_sel_b    (alu_sel_b),
    .alu_flag_set (alu_flag_set),
    .inst_op      (inst_op),
    .reg_a        (reg_a),
    .reg1         (reg1),
    .reg2         (reg2),
    .flag_read    (flag_read),
    .alu_out      (alu_out),
    .flag_next    (flag_next),
    .flag_write   (flag_write)
  );

  // Reference: returns {out[7:0], flags{Z,N,H,C}, write}
  function automatic logic [12:0] model(input logic [2:0] op, input logic sa, input logic sb,
                                        input logic [1:0] fs, input logic [2:0] io,
                                        input logic [7:0] ra, input logic [7:0] r1,
                                        input logic [7:0] r2, input logic [3:0] fr,
                                        input logic ic);
    int a, b, r, d, adj, kind, cc;
    logic z, n, h, c;
    logic [3:0] fin, cf, fo;
    a = sa ? int'(r1) : int'(ra);
    b = sb ? (r2[7] ? 255 : 0) : int'(r2);
    fin = (op == 3'd5) ? {3'b000, ic} : fr;
    {z, n, h, c} = fin;
    r = a;
    kind = -1;
    if (op == 3'd4) kind = 0;
    else if (op == 3'd5) kind = 1;
    else if (op == 3'd6) kind = int'(io);
    case (kind)
      0, 1: begin
        cc = (kind == 1) ? int'(c) : 0;
        r = a + b + cc;
        h = ((a % 16) + (b % 16) + cc) > 15;
        c = r > 255;
        r = r % 256; n = 0; z = (r == 0);
      end
      2, 3, 7: begin
        cc = (kind == 3) ? int'(c) : 0;
        d = a - b - cc;
        h = ((a % 16) - (b % 16) - cc) < 0;
        c = d < 0;
        r = (d + 256) % 256; n = 1; z = (r == 0);
        if (kind == 7) r = a;
      end
      4: begin r = a & b; z = (r == 0); n = 0; h = 1; c = 0; end
      5: begin r = a ^ b; z = (r == 0); n = 0; h = 0; c = 0; end
      6: begin r = a | b; z = (r == 0); n = 0; h = 0; c = 0; end
      default: ;
    endcase
    if (op == 3'd7) begin
      case (io)
        3'd0: begin r = (a * 2) % 256 + a / 128; c = (a >= 128); z = 0; n = 0; h = 0; end
        3'd1: begin r = a / 2 + (a % 2) * 128; c = (a % 2 == 1); z = 0; n = 0; h = 0; end
        3'd2: begin r = (a * 2) % 256 + int'(c); c = (a >= 128); z = 0; n = 0; h = 0; end
        3'd3: begin r = a / 2 + int'(c) * 128; c = (a % 2 == 1); z = 0; n = 0; h = 0; end
        3'd4: begin
          adj = 0;
          if (!n) begin
            if (c || a > 153) begin adj += 96; c = 1; end
            if (h || (a % 16) > 9) adj += 6;
            r = (a + adj) % 256;
          end else begin
            if (c) adj += 96;
            if (h) adj += 6;
            r = (a - adj + 256) % 256;
          end
          z = (r == 0); h = 0;
        end
        3'd5: begin r = 255 - a; n = 1; h = 1; end
        3'd6: begin n = 0; h = 0; c = 1; end
        default: begin n = 0; h = 0; c = !c; end
      endcase
    end
    if (op == 3'd1) r = b;
    if (op == 3'd2) begin r = (b + 1) % 256; z = (r == 0); n = 0; h = ((b % 16) == 15); end
    if (op == 3'd3) begin r = (b + 255) % 256; z = (r == 0); n = 1; h = ((b % 16) == 0); end
    cf = {z, n, h, c};
    case (fs)
      2'd0: fo = fin;
      2'd1: fo = cf;
      2'd2: fo = {fr[3], cf[2:0]};
      default: fo = {1'b0, cf[2:0]};
    endcase
    return {r[7:0], fo, fs != 2'd0};
  endfunction

  task automatic drive(input logic [2:0] op, input logic sa, input logic sb, input logic [1:0] fs,
                       input logic [2:0] io, input logic [7:0] ra, input logic [7:0] r1,
                       input logic [7:0] r2, input logic [3:0] fr, input logic [1:0] tc);
    alu_op = op; alu_sel_a = sa; alu_sel_b = sb; alu_flag_set = fs; inst_op = io;
    reg_a = ra; reg1 = r1; reg2 = r2; flag_read = fr; t_cycle = tc;
    #2;
  endtask

  // Advance one clock, tracking the saved low-byte carry in the model
  task automatic clock_edge();
    logic [12:0] m;
    m = model(alu_op, alu_sel_a, alu_sel_b, 2'd1, inst_op, reg_a, reg1, reg2, flag_read, m_icarry);
    @(posedge clk);
    if (reset) m_icarry = 1'b0;
    else if (t_cycle == 2'd3 && alu_op == 3'd4) m_icarry = m[1];
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(3'd4, 1'b1, 1'b0, 2'd1, 3'd0, 8'h00, 8'hF8, 8'h10, 4'h0, 2'd3);
    clock_edge();
    clock_edge();
    reset = 1'b0;
    drive(3'd5, 1'b1, 1'b1, 2'd1, 3'd0, 8'h00, 8'hFF, 8'h00, 4'hF, 2'd0);
    total++;
    if ({alu_out, flag_next, flag_write} !== {8'hFF, 4'b0000, 1'b1}) begin
      bad++;
      $display("FAIL reset_addhi: got out=%h flags=%b wr=%b expected out=ff flags=0000 wr=1",
               alu_out, flag_next, flag_write);
    end
  endtask

  typedef struct packed {
    logic [2:0] op; logic sa; logic sb; logic [1:0] fs; logic [2:0] io;
    logic [7:0] ra; logic [7:0] r2; logic [3:0] fr;
    logic [7:0] eo; logic [3:0] ef; logic ew;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    v[0] = '{3'd6, 1'b0, 1'b0, 2'd1, 3'd0, 8'h3A, 8'hC6, 4'h0, 8'h00, 4'b1011, 1'b1};
    v[1] = '{3'd6, 1'b0, 1'b0, 2'd1, 3'd2, 8'h3E, 8'h3E, 4'h0, 8'h00, 4'b1100, 1'b1};
    v[2] = '{3'd6, 1'b0, 1'b0, 2'd1, 3'd7, 8'h3C, 8'h40, 4'h0, 8'h3C, 4'b0101, 1'b1};
    v[3] = '{3'd7, 1'b0, 1'b0, 2'd1, 3'd4, 8'h3C, 8'h00, 4'h0, 8'h42, 4'b0000, 1'b1};
    v[4] = '{3'd7, 1'b0, 1'b0, 2'd1, 3'd4, 8'h9A, 8'h00, 4'h0, 8'h00, 4'b1001, 1'b1};
    v[5] = '{3'd2, 1'b0, 1'b0, 2'd2, 3'd0, 8'h00, 8'h0F, 4'b1001, 8'h10, 4'b1011, 1'b1};
    v[6] = '{3'd3, 1'b0, 1'b0, 2'd1, 3'd0, 8'h00, 8'h01, 4'b0001, 8'h00, 4'b1101, 1'b1};
    v[7] = '{3'd3, 1'b0, 1'b0, 2'd0, 3'd0, 8'h00, 8'h01, 4'b1010, 8'h00, 4'b1010, 1'b0};
    v[8] = '{3'd7, 1'b0, 1'b0, 2'd1, 3'd2, 8'h80, 8'h00, 4'b0001, 8'h01, 4'b0001, 1'b1};
    v[9] = '{3'd6, 1'b0, 1'b0, 2'd3, 3'd0, 8'h00, 8'h00, 4'b1000, 8'h00, 4'b0000, 1'b1};
    for (int i = 0; i < 10; i++) begin
      drive(v[i].op, v[i].sa, v[i].sb, v[i].fs, v[i].io, v[i].ra, 8'h00, v[i].r2, v[i].fr, 2'd0);
      total++;
      if ({alu_out, flag_next, flag_write} !== {v[i].eo, v[i].ef, v[i].ew}) begin
        bad++;
        $display("FAIL directed_%0d: got out=%h flags=%b wr=%b expected out=%h flags=%b wr=%b",
                 i, alu_out, flag_next, flag_write, v[i].eo, v[i].ef, v[i].ew);
      end
      clock_edge();
    end
  endtask

  task automatic test_icarry_chain();
    logic [7:0] exp_hi[4];
    exp_hi = '{8'h00, 8'h00, 8'h00, 8'hFF};
    drive(3'd4, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00, 8'hF8, 8'h10, 4'h0, 2'd3);
    total++;
    if (alu_out !== 8'h08) begin
      bad++;
      $display("FAIL addlo_out: got %h expected 08", alu_out);
    end
    clock_edge();
    for (int step = 0; step < 4; step++) begin
      drive(3'd5, 1'b1, 1'b1, 2'd0, 3'd0, 8'h00, 8'hFF, (step == 3) ? 8'h00 : 8'h10, 4'h0,
            2'd3);
      total++;
      if ({alu_out, flag_next, flag_write} !== {exp_hi[step], 3'b000, step != 3, 1'b0}) begin
        bad++;
        $display("FAIL addhi_step%0d: got out=%h flags=%b wr=%b expected out=%h flags=%b wr=0",
                 step, alu_out, flag_next, flag_write, exp_hi[step], {3'b000, step != 3});
      end
      clock_edge();
      if (step == 1) begin
        drive(3'd4, 1'b0, 1'b0, 2'd1, 3'd0, 8'h01, 8'h00, 8'h01, 4'h0, 2'd2);
        clock_edge();
      end
      if (step == 2) begin
        reset = 1'b1;
        drive(3'd4, 1'b1, 1'b0, 2'd1, 3'd0, 8'h00, 8'hF8, 8'h10, 4'h0, 2'd3);
        clock_edge();
        reset = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] exp;
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 2'($urandom));
      exp = model(alu_op, alu_sel_a, alu_sel_b, alu_flag_set, inst_op, reg_a, reg1, reg2,
                  flag_read, m_icarry);
      total++;
      if ({alu_out, flag_next, flag_write} !== exp) begin
        bad++;
        $display("FAIL random_%0d op=%0d io=%0d fs=%0d a=%h r1=%h r2=%h fr=%b: got %h/%b/%b expected %h/%b/%b",
                 i, alu_op, inst_op, alu_flag_set, reg_a, reg1, reg2, flag_read,
                 alu_out, flag_next, flag_write, exp[12:5], exp[4:1], exp[0]);
      end
      clock_edge();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(3'd0, 1'b0, 1'b0, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 4'h0, 2'd0);
    @(negedge clk);
    test_reset();
    test_directed();
    test_icarry_chain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
